// File: rtl/bus_share_arbiter4.sv
// Four-requester round-robin arbiter with burst lock, driving a shared 4:1
// word multiplexer and a single-entry valid/ready output register.

// One 4-bit slice of the shared 4:1 word multiplexer.
module bus_share_mux4_slice (
   input  logic [1:0] sel_i,
   input  logic [3:0] d0_i,
   input  logic [3:0] d1_i,
   input  logic [3:0] d2_i,
   input  logic [3:0] d3_i,
   output logic [3:0] y_o
);
   // Plain 4:1 select; sel_i[1] is C1, sel_i[0] is C0.
   always_comb begin
      case (sel_i)
         2'd0:    y_o = d0_i;
         2'd1:    y_o = d1_i;
         2'd2:    y_o = d2_i;
         default: y_o = d3_i;
      endcase
   end
endmodule

module bus_share_arbiter4 #(
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [3:0]       lock,
   input  logic [WIDTH-1:0] data_0,
   input  logic [WIDTH-1:0] data_1,
   input  logic [WIDTH-1:0] data_2,
   input  logic [WIDTH-1:0] data_3,
   output logic [3:0]       ack,
   output logic [1:0]       sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_src,
   input  logic             out_ready
);
   localparam int         NSLICE  = WIDTH / 4;
   // Burst hold is allowed while the count is below this limit.
   localparam logic [3:0] CNT_LIM = 4'(MAX_BURST - 1);

   logic [1:0]       last_q, last_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [1:0]       sel_q;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       src_q, src_d;

   logic [1:0]       rr_win, winner, sel_mux, idx;
   logic             found, hold, any_req, space, accept;
   logic [WIDTH-1:0] mux_y;

   // Winner selection: burst hold on the last winner, else round-robin
   // scanning from last+1 and wrapping back to last itself.
   always_comb begin
      hold   = lock[last_q] && req[last_q] && (cnt_q < CNT_LIM);
      rr_win = last_q;
      found  = 1'b0;
      idx    = last_q;
      for (int k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!found && req[idx]) begin
            rr_win = idx;
            found  = 1'b1;
         end
      end
      winner  = hold ? last_q : rr_win;
      any_req = |req;
      space   = !valid_q || out_ready;
      accept  = space && any_req;
      // With no request the select parks on its previous value.
      sel_mux = any_req ? winner : sel_q;
      sel     = rst_n ? sel_mux : 2'd0;
      ack     = (accept && rst_n) ? (4'd1 << winner) : 4'd0;
   end

   // Shared word multiplexer built from 4-bit slices.
   for (genvar g = 0; g < NSLICE; g++) begin : g_slice
      bus_share_mux4_slice u_slice (
         .sel_i (sel_mux),
         .d0_i  (data_0[g*4 +: 4]),
         .d1_i  (data_1[g*4 +: 4]),
         .d2_i  (data_2[g*4 +: 4]),
         .d3_i  (data_3[g*4 +: 4]),
         .y_o   (mux_y[g*4 +: 4])
      );
   end

   // Next-state: capture on accept (replacing a word drained this cycle),
   // otherwise drain or hold.
   always_comb begin
      last_d  = last_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      data_d  = data_q;
      src_d   = src_q;
      if (accept) begin
         data_d  = mux_y;
         src_d   = winner;
         valid_d = 1'b1;
         if (hold) begin
            cnt_d = cnt_q + 4'd1;
         end else begin
            cnt_d  = 4'd0;
            last_d = winner;
         end
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   // State registers; reset discards any pending word immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q  <= 2'd3;
         cnt_q   <= 4'd0;
         sel_q   <= 2'd0;
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= 2'd0;
      end else begin
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_mux;
         valid_q <= valid_d;
         data_q  <= data_d;
         src_q   <= src_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_src   = src_q;
endmodule

// File: tb/tb_bus_share_arbiter4.sv
// Bench for bus_share_arbiter4: vector table, hand sequences for the
// backpressure / drain / reset corners, then random traffic against a
// rule-level reference model.
module tb_bus_share_arbiter4;
   localparam int W  = 32;
   localparam int MB = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req = '0;
   logic [3:0]   lock = '0;
   logic [W-1:0] data_0 = '0, data_1 = '0, data_2 = '0, data_3 = '0;
   logic         out_ready = 1'b0;
   logic [3:0]   ack;
   logic [1:0]   sel;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   out_src;

   bus_share_arbiter4 #(.WIDTH(W), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .lock      (lock),
      .data_0    (data_0),
      .data_1    (data_1),
      .data_2    (data_2),
      .data_3    (data_3),
      .ack       (ack),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int          m_last, m_cnt, m_src, m_sel;
   bit          m_valid;
   logic [31:0] m_data;
   logic [3:0]  got_ack;
   logic [1:0]  got_sel;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [3:0]  lock;
      logic        rdy;
      logic [3:0]  ack;
      logic [1:0]  sel;
      logic [31:0] dat;
   } vec_t;
   vec_t tbl[20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_of(input int i);
      case (i)
         0:       return data_0;
         1:       return data_1;
         2:       return data_2;
         default: return data_3;
      endcase
   endfunction

   task automatic m_reset();
      m_last = 3; m_cnt = 0; m_valid = 0; m_data = '0; m_src = 0; m_sel = 0;
   endtask

   function automatic vec_t mk(input logic r0, input logic [3:0] rq, input logic [3:0] lk,
                               input logic [3:0] ak, input logic [1:0] sl, input logic [31:0] d);
      vec_t v;
      v.rst = r0; v.req = rq; v.lock = lk; v.rdy = 1'b1; v.ack = ak; v.sel = sl; v.dat = d;
      return v;
   endfunction

   // One clock: apply inputs, compare everything against the model just
   // before the edge, advance the model, then step past the edge.
   task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic rd);
      int         w;
      bit         hold, acc;
      logic [3:0] e_ack;
      int         e_sel;
      req = r; lock = l; out_ready = rd;
      @(negedge clk);
      hold = l[m_last] && r[m_last] && (m_cnt < MB - 1);
      w = m_last;
      if (!hold) begin
         for (int k = 1; k <= 4; k++) begin
            if (r[(m_last + k) % 4]) begin
               w = (m_last + k) % 4;
               break;
            end
         end
      end
      acc   = (!m_valid || rd) && (r != 4'd0);
      e_ack = acc ? 4'(1 << w) : 4'd0;
      e_sel = (r != 4'd0) ? w : m_sel;
      got_ack = ack;
      got_sel = sel;
      chk("ack", 32'(ack), 32'(e_ack));
      chk("sel", 32'(sel), 32'(e_sel));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data", out_data, m_data);
      chk("out_src", 32'(out_src), 32'(m_src));
      if (acc) begin
         m_data  = word_of(w);
         m_src   = w;
         m_valid = 1;
         if (hold) m_cnt++;
         else begin
            m_cnt  = 0;
            m_last = w;
         end
      end else if (m_valid && rd) begin
         m_valid = 0;
      end
      m_sel = e_sel;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; lock = '0;
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      // Round-robin over all four, no lock
      tbl[0]  = mk(1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 32'hA0);
      tbl[1]  = mk(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 32'hA1);
      tbl[2]  = mk(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 32'hA2);
      tbl[3]  = mk(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 32'hA3);
      tbl[4]  = mk(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 32'hA0);
      // Locked requester 0 against requester 2, MAX_BURST=4
      tbl[5]  = mk(1, 4'b0101, 4'b0001, 4'b0001, 2'd0, 32'hA0);
      tbl[6]  = mk(0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 32'hA0);
      tbl[7]  = mk(0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 32'hA0);
      tbl[8]  = mk(0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 32'hA0);
      tbl[9]  = mk(0, 4'b0101, 4'b0001, 4'b0100, 2'd2, 32'hA2);
      tbl[10] = mk(0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 32'hA0);
      tbl[11] = mk(0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 32'hA0);
      tbl[12] = mk(0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 32'hA0);
      tbl[13] = mk(0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 32'hA0);
      tbl[14] = mk(0, 4'b0101, 4'b0001, 4'b0100, 2'd2, 32'hA2);
      // Lock dropped after two beats
      tbl[15] = mk(1, 4'b0011, 4'b0001, 4'b0001, 2'd0, 32'hA0);
      tbl[16] = mk(0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 32'hA0);
      tbl[17] = mk(0, 4'b0011, 4'b0000, 4'b0010, 2'd1, 32'hA1);
      tbl[18] = mk(0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 32'hA0);
      tbl[19] = mk(0, 4'b0011, 4'b0000, 4'b0010, 2'd1, 32'hA1);

      data_0 = 32'hA0; data_1 = 32'hA1; data_2 = 32'hA2; data_3 = 32'hA3;

      // Reset state, with requests present while reset is held
      #2 req = 4'b1111; out_ready = 1'b1;
      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_src", 32'(out_src), 32'd0);

      for (int i = 0; i < 20; i++) begin
         if (tbl[i].rst) do_reset();
         cyc(tbl[i].req, tbl[i].lock, tbl[i].rdy);
         chk("tbl_ack", 32'(got_ack), 32'(tbl[i].ack));
         chk("tbl_sel", 32'(got_sel), 32'(tbl[i].sel));
         chk("tbl_valid", 32'(out_valid), 32'd1);
         chk("tbl_data", out_data, tbl[i].dat);
      end

      // Backpressure: hold DEADBEEF from requester 1 for five cycles
      do_reset();
      data_1 = 32'hDEADBEEF;
      cyc(4'b0001, 4'b0000, 1'b1);
      cyc(4'b0010, 4'b0000, 1'b1);
      chk("bp_first_ack", 32'(got_ack), 32'b0010);
      for (int i = 0; i < 5; i++) begin
         cyc(4'b1111, 4'b0000, 1'b0);
         chk("bp_ack", 32'(got_ack), 32'd0);
         chk("bp_data", out_data, 32'hDEADBEEF);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_src", 32'(out_src), 32'd1);
      end
      cyc(4'b1111, 4'b0000, 1'b1);
      chk("bp_release_ack", 32'(got_ack), 32'b0100);

      // Simultaneous drain and accept: no bubbles
      for (int i = 0; i < 6; i++) begin
         cyc(4'b1000, 4'b0000, 1'b1);
         chk("drain_ack", 32'(got_ack), 32'b1000);
         chk("drain_valid", 32'(out_valid), 32'd1);
      end

      // Reset mid-burst with a pending word
      cyc(4'b0001, 4'b0001, 1'b0);
      cyc(4'b0001, 4'b0001, 1'b0);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      req = 4'b1111;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_ack", 32'(ack), 32'd0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      req = '0;
      @(posedge clk); #1;
      cyc(4'b1111, 4'b0000, 1'b1);
      chk("postrst_ack", 32'(got_ack), 32'b0001);

      // Random traffic against the model
      for (int i = 0; i < 500; i++) begin
         data_0 = $urandom; data_1 = $urandom; data_2 = $urandom; data_3 = $urandom;
         cyc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
